// File: rtl/cq_req_depacketizer.sv
// Completer-request depacketizer: splits each 128-bit CQ request into a registered
// descriptor and a write-payload stream realigned so payload DW0 lands in tdata[31:0].
module cq_req_depacketizer #(
   parameter int DATA_WIDTH = 128,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  user_clk,
   input  logic                  user_reset_n,

   input  logic [DATA_WIDTH-1:0] m_axis_cq_tdata,
   input  logic [KEEP_WIDTH-1:0] m_axis_cq_tkeep,
   input  logic                  m_axis_cq_tlast,
   output logic [3:0]            m_axis_cq_tready,
   input  logic [84:0]           m_axis_cq_tuser,
   input  logic                  m_axis_cq_tvalid,

   output logic                  req_valid,
   input  logic                  req_ready,
   output logic                  req_we,
   output logic [10:0]           req_len,
   output logic [31:0]           req_addr,
   output logic [15:0]           req_reqid,
   output logic [7:0]            req_tag,
   output logic [3:0]            req_first_be,
   output logic [3:0]            req_last_be,
   output logic [2:0]            req_tc,
   output logic [1:0]            req_attr,
   output logic [7:0]            req_barhit,

   output logic [DATA_WIDTH-1:0] wr_tdata,
   output logic [KEEP_WIDTH-1:0] wr_tkeep,
   output logic                  wr_tlast,
   output logic                  wr_tvalid,
   input  logic                  wr_tready,

   output logic                  err_len
);

   // Every channel uses AXI-stream rules: a transfer happens on a clock edge where
   // valid && ready; once valid is raised, data/fields hold until that transfer.

   typedef enum logic [1:0] {
      ST_HDR   = 2'd0,
      ST_DATA  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DROP  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] carry;
   logic [10:0] rem;
   logic        err_nxt;
   logic        rdy;
   logic        cq_ready;
   logic        cq_fire;
   logic        hdr_fire;
   logic        data_step;
   logic        hdr_we;
   logic [10:0] hdr_len;
   logic        unused_inputs;

   assign hdr_we   = m_axis_cq_tdata[30];
   assign hdr_len  = (m_axis_cq_tdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, m_axis_cq_tdata[9:0]};

   // Hold the input stalled while reset is asserted, whatever the state decode says.
   assign cq_ready = rdy && user_reset_n;
   assign m_axis_cq_tready = {4{cq_ready}};
   assign cq_fire  = m_axis_cq_tvalid && cq_ready;
   assign hdr_fire = (state == ST_HDR) && cq_fire;
   assign data_step = (state == ST_DATA) && cq_fire && (rem > 11'd4);

   assign unused_inputs = ^{m_axis_cq_tkeep, m_axis_cq_tuser[84:10], m_axis_cq_tuser[1:0],
                            m_axis_cq_tdata[31], m_axis_cq_tdata[29:23], m_axis_cq_tdata[19:10]};

   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         state <= ST_HDR;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      case (state)
         ST_HDR: begin
            if (cq_fire) begin
               if (!hdr_we) begin
                  if (!m_axis_cq_tlast) begin
                     err_nxt   = 1'b1;
                     state_nxt = ST_DROP;
                  end
               end else if (m_axis_cq_tlast) begin
                  // Single-beat write: DW3 is the only payload word, emitted by FLUSH.
                  err_nxt   = (hdr_len != 11'd1);
                  state_nxt = ST_FLUSH;
               end else begin
                  state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (cq_fire) begin
               if (rem <= 11'd4) begin
                  err_nxt   = !m_axis_cq_tlast;
                  state_nxt = m_axis_cq_tlast ? ST_HDR : ST_DROP;
               end else if (m_axis_cq_tlast) begin
                  if (rem == 11'd5) begin
                     state_nxt = ST_FLUSH;
                  end else begin
                     err_nxt   = 1'b1;
                     state_nxt = ST_HDR;
                  end
               end
            end
         end
         ST_FLUSH: begin
            if (wr_tready) begin
               state_nxt = ST_HDR;
            end
         end
         ST_DROP: begin
            if (cq_fire && m_axis_cq_tlast) begin
               state_nxt = ST_HDR;
            end
         end
         default: state_nxt = ST_HDR;
      endcase
   end

   always_comb begin
      rdy       = 1'b0;
      wr_tvalid = 1'b0;
      wr_tdata  = '0;
      wr_tkeep  = '0;
      wr_tlast  = 1'b0;
      case (state)
         ST_HDR: begin
            rdy = !req_valid || req_ready;
         end
         ST_DATA: begin
            rdy       = wr_tready;
            wr_tvalid = m_axis_cq_tvalid;
            wr_tdata  = {m_axis_cq_tdata[95:0], carry};
            if (rem <= 11'd4) begin
               wr_tlast = 1'b1;
               case (rem[2:0])
                  3'd1:    wr_tkeep = 16'h000F;
                  3'd2:    wr_tkeep = 16'h00FF;
                  3'd3:    wr_tkeep = 16'h0FFF;
                  default: wr_tkeep = 16'hFFFF;
               endcase
            end else begin
               wr_tkeep = 16'hFFFF;
               // Early tlast with more than one word still owed truncates the payload here.
               wr_tlast = m_axis_cq_tlast && (rem != 11'd5);
            end
         end
         ST_FLUSH: begin
            wr_tvalid = 1'b1;
            wr_tdata  = {96'b0, carry};
            wr_tkeep  = 16'h000F;
            wr_tlast  = 1'b1;
         end
         ST_DROP: begin
            rdy = 1'b1;
         end
         default: begin
            rdy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         carry        <= '0;
         rem          <= '0;
         err_len      <= 1'b0;
         req_valid    <= 1'b0;
         req_we       <= 1'b0;
         req_len      <= '0;
         req_addr     <= '0;
         req_reqid    <= '0;
         req_tag      <= '0;
         req_first_be <= '0;
         req_last_be  <= '0;
         req_tc       <= '0;
         req_attr     <= '0;
         req_barhit   <= '0;
      end else begin
         err_len <= err_nxt;
         if (hdr_fire) begin
            req_valid    <= 1'b1;
            req_we       <= hdr_we;
            req_len      <= hdr_len;
            req_addr     <= m_axis_cq_tdata[95:64];
            req_reqid    <= m_axis_cq_tdata[63:48];
            req_tag      <= m_axis_cq_tdata[47:40];
            req_last_be  <= m_axis_cq_tdata[39:36];
            req_first_be <= m_axis_cq_tdata[35:32];
            req_tc       <= m_axis_cq_tdata[22:20];
            req_attr     <= m_axis_cq_tdata[5:4];
            req_barhit   <= m_axis_cq_tuser[9:2];
            carry        <= m_axis_cq_tdata[127:96];
            rem          <= hdr_len;
         end else begin
            if (req_ready) begin
               req_valid <= 1'b0;
            end
            if (data_step) begin
               carry <= m_axis_cq_tdata[127:96];
               rem   <= rem - 11'd4;
            end
         end
      end
   end

endmodule

// File: tb/tb_cq_req_depacketizer.sv
// Directed bench for cq_req_depacketizer: header decode, payload realignment,
// FLUSH/DROP paths, descriptor back-pressure and reset behaviour.
module tb_cq_req_depacketizer;

   logic          user_clk = 1'b0;
   logic          user_reset_n = 1'b0;
   logic [127:0]  m_axis_cq_tdata = '0;
   logic [15:0]   m_axis_cq_tkeep = '0;
   logic          m_axis_cq_tlast = 1'b0;
   logic [3:0]    m_axis_cq_tready;
   logic [84:0]   m_axis_cq_tuser = '0;
   logic          m_axis_cq_tvalid = 1'b0;
   logic          req_valid;
   logic          req_ready = 1'b1;
   logic          req_we;
   logic [10:0]   req_len;
   logic [31:0]   req_addr;
   logic [15:0]   req_reqid;
   logic [7:0]    req_tag;
   logic [3:0]    req_first_be;
   logic [3:0]    req_last_be;
   logic [2:0]    req_tc;
   logic [1:0]    req_attr;
   logic [7:0]    req_barhit;
   logic [127:0]  wr_tdata;
   logic [15:0]   wr_tkeep;
   logic          wr_tlast;
   logic          wr_tvalid;
   logic          wr_tready = 1'b1;
   logic          err_len;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int err_cnt = 0;

   logic [144:0] obs_q[$];
   logic [144:0] exp_q[$];
   logic [88:0]  desc_q[$];
   logic [88:0]  exp_desc_q[$];

   cq_req_depacketizer dut (
      .user_clk         (user_clk),
      .user_reset_n     (user_reset_n),
      .m_axis_cq_tdata  (m_axis_cq_tdata),
      .m_axis_cq_tkeep  (m_axis_cq_tkeep),
      .m_axis_cq_tlast  (m_axis_cq_tlast),
      .m_axis_cq_tready (m_axis_cq_tready),
      .m_axis_cq_tuser  (m_axis_cq_tuser),
      .m_axis_cq_tvalid (m_axis_cq_tvalid),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_len          (req_len),
      .req_addr         (req_addr),
      .req_reqid        (req_reqid),
      .req_tag          (req_tag),
      .req_first_be     (req_first_be),
      .req_last_be      (req_last_be),
      .req_tc           (req_tc),
      .req_attr         (req_attr),
      .req_barhit       (req_barhit),
      .wr_tdata         (wr_tdata),
      .wr_tkeep         (wr_tkeep),
      .wr_tlast         (wr_tlast),
      .wr_tvalid        (wr_tvalid),
      .wr_tready        (wr_tready),
      .err_len          (err_len)
   );

   // Clock / reset
   always #5 user_clk = ~user_clk;
   always @(posedge user_clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   // Output monitors sample on the falling edge, half a cycle away from the active edge.
   always @(negedge user_clk) begin
      if (user_reset_n) begin
         if (wr_tvalid && wr_tready) obs_q.push_back({wr_tlast, wr_tkeep, wr_tdata});
         if (req_valid && req_ready)
            desc_q.push_back({req_we, req_len, req_addr, req_reqid, req_tag, req_first_be,
                              req_last_be, req_tc, req_attr, req_barhit});
         if (err_len) err_cnt++;
      end
   end

   function automatic logic [127:0] mk_hdr(input logic we, input logic [9:0] len, input logic [2:0] tc,
                                           input logic [15:0] reqid, input logic [7:0] tag,
                                           input logic [3:0] lbe, input logic [3:0] fbe,
                                           input logic [31:0] addr, input logic [31:0] dw3);
      return {dw3, addr, reqid, tag, lbe, fbe, 1'b0, we, 7'b0, tc, 10'b0, len};
   endfunction

   function automatic logic [88:0] mk_desc(input logic we, input logic [10:0] len, input logic [31:0] addr,
                                           input logic [15:0] reqid, input logic [7:0] tag,
                                           input logic [3:0] fbe, input logic [3:0] lbe,
                                           input logic [2:0] tc, input logic [1:0] attr,
                                           input logic [7:0] bar);
      return {we, len, addr, reqid, tag, fbe, lbe, tc, attr, bar};
   endfunction

   function automatic logic [31:0] dw(input int i);
      return 32'hA500_0000 + 32'(i);
   endfunction

   // Driver: present one beat and hold it until the DUT takes it; returns at posedge+1.
   task automatic drive_beat(input logic [127:0] d, input logic last, input logic [7:0] bar);
      int  n;
      logic done;
      n    = 0;
      done = 1'b0;
      m_axis_cq_tdata  = d;
      m_axis_cq_tkeep  = 16'hFFFF;
      m_axis_cq_tlast  = last;
      m_axis_cq_tuser  = {75'b0, bar, 2'b00};
      m_axis_cq_tvalid = 1'b1;
      while (!done && n < 200) begin
         @(negedge user_clk);
         if (m_axis_cq_tready[0]) begin
            @(posedge user_clk);
            #1;
            done = 1'b1;
         end else begin
            n++;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL beat_accept_timeout: got no tready in 200 cycles expected acceptance");
      end
      m_axis_cq_tvalid = 1'b0;
      m_axis_cq_tlast  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge user_clk);
      #1;
   endtask

   task automatic test_reset();
      user_reset_n = 1'b0;
      idle(3);
      checks++;
      if (m_axis_cq_tready !== 4'h0) begin
         errors++; $display("FAIL reset_tready: got %h expected 0", m_axis_cq_tready);
      end
      checks++;
      if ({req_valid, wr_tvalid, wr_tlast, err_len} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", {req_valid, wr_tvalid, wr_tlast, err_len});
      end
      checks++;
      if (req_len !== 11'd0 || req_addr !== 32'd0 || req_tag !== 8'd0) begin
         errors++; $display("FAIL reset_desc: got len=%0d addr=%h tag=%h expected zeros", req_len, req_addr, req_tag);
      end
      user_reset_n = 1'b1;
      idle(1);
      checks++;
      if (m_axis_cq_tready !== 4'hF) begin
         errors++; $display("FAIL release_tready: got %h expected f", m_axis_cq_tready);
      end
   endtask

   task automatic test_mrd();
      int d0, e0;
      d0 = desc_q.size();
      e0 = err_cnt;
      drive_beat(mk_hdr(1'b0, 10'd1, 3'd0, 16'h0100, 8'h12, 4'h0, 4'hF, 32'h0000_1000, 32'h0), 1'b1, 8'h01);
      checks++;
      if (req_valid !== 1'b1 || req_we !== 1'b0 || req_len !== 11'd1 || req_addr !== 32'h1000 ||
          req_tag !== 8'h12 || req_barhit !== 8'h01) begin
         errors++;
         $display("FAIL mrd_latency: got v=%b we=%b len=%0d addr=%h tag=%h bar=%h expected 1 0 1 00001000 12 01",
                  req_valid, req_we, req_len, req_addr, req_tag, req_barhit);
      end
      checks++;
      if (wr_tvalid !== 1'b0) begin
         errors++; $display("FAIL mrd_no_payload: got wr_tvalid=%b expected 0", wr_tvalid);
      end
      drive_beat(mk_hdr(1'b0, 10'h3F, 3'd5, 16'hBEEF, 8'h77, 4'hC, 4'h3, 32'hFFFF_FFFC, 32'h0), 1'b1, 8'h80);
      idle(2);
      exp_desc_q.push_back(mk_desc(1'b0, 11'd1, 32'h1000, 16'h0100, 8'h12, 4'hF, 4'h0, 3'd0, 2'd0, 8'h01));
      exp_desc_q.push_back(mk_desc(1'b0, 11'd63, 32'hFFFF_FFFC, 16'hBEEF, 8'h77, 4'h3, 4'hC, 3'd5, 2'd3, 8'h80));
      checks++;
      if (desc_q.size() !== d0 + exp_desc_q.size()) begin
         errors++; $display("FAIL mrd_desc_count: got %0d expected %0d", desc_q.size() - d0, exp_desc_q.size());
      end else foreach (exp_desc_q[k]) begin
         checks++;
         if (desc_q[d0 + k] !== exp_desc_q[k]) begin
            errors++; $display("FAIL mrd_desc%0d: got %h expected %h", k, desc_q[d0 + k], exp_desc_q[k]);
         end
      end
      exp_desc_q.delete();
      checks++;
      if (err_cnt !== e0) begin
         errors++; $display("FAIL mrd_err_len: got %0d pulses expected 0", err_cnt - e0);
      end
   endtask

   task automatic test_mwr_len1();
      int o0, d0;
      o0 = obs_q.size();
      d0 = desc_q.size();
      wr_tready = 1'b0;
      drive_beat(mk_hdr(1'b1, 10'd1, 3'd0, 16'h0200, 8'h21, 4'h0, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF), 1'b1, 8'h02);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (m_axis_cq_tready !== 4'h0 || wr_tvalid !== 1'b1 || wr_tdata !== {96'b0, 32'hDEAD_BEEF} ||
             wr_tkeep !== 16'h000F || wr_tlast !== 1'b1) begin
            errors++;
            $display("FAIL flush_beat%0d: got rdy=%h v=%b data=%h keep=%h last=%b expected 0 1 ..deadbeef 000f 1",
                     i, m_axis_cq_tready, wr_tvalid, wr_tdata, wr_tkeep, wr_tlast);
         end
         idle(1);
      end
      wr_tready = 1'b1;
      idle(1);
      checks++;
      if (wr_tvalid !== 1'b0 || m_axis_cq_tready !== 4'hF) begin
         errors++; $display("FAIL flush_exit: got v=%b rdy=%h expected 0 f", wr_tvalid, m_axis_cq_tready);
      end
      checks++;
      if (obs_q.size() !== o0 + 1) begin
         errors++; $display("FAIL len1_beats: got %0d expected 1", obs_q.size() - o0);
      end else begin
         checks++;
         if (obs_q[o0] !== {1'b1, 16'h000F, 96'b0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL len1_beat: got %h expected flush of deadbeef", obs_q[o0]);
         end
      end
      checks++;
      if (desc_q.size() !== d0 + 1 || desc_q[d0] !== mk_desc(1'b1, 11'd1, 32'h2000, 16'h0200, 8'h21, 4'hF, 4'h0, 3'd0, 2'd0, 8'h02)) begin
         errors++; $display("FAIL len1_desc: got count %0d expected one write len1 descriptor", desc_q.size() - d0);
      end
   endtask

   task automatic test_mwr_back_to_back();
      int o0, d0, e0, c0;
      o0 = obs_q.size();
      d0 = desc_q.size();
      e0 = err_cnt;
      drive_beat(mk_hdr(1'b1, 10'd8, 3'd1, 16'h0300, 8'h31, 4'hF, 4'hF, 32'h0000_3000, dw(0)), 1'b0, 8'h04);
      drive_beat({dw(4), dw(3), dw(2), dw(1)}, 1'b0, 8'h00);
      drive_beat({32'h0, dw(7), dw(6), dw(5)}, 1'b1, 8'h00);
      c0 = cyc;
      drive_beat(mk_hdr(1'b1, 10'd6, 3'd0, 16'h0301, 8'h32, 4'h3, 4'hE, 32'h0000_3100, dw(100)), 1'b0, 8'h04);
      checks++;
      if (cyc !== c0 + 1) begin
         errors++; $display("FAIL b2b_header_gap: got %0d cycles expected 1", cyc - c0);
      end
      drive_beat({dw(104), dw(103), dw(102), dw(101)}, 1'b0, 8'h00);
      drive_beat({96'h0, dw(105)}, 1'b1, 8'h00);
      idle(2);
      exp_q.push_back({1'b0, 16'hFFFF, dw(3), dw(2), dw(1), dw(0)});
      exp_q.push_back({1'b1, 16'hFFFF, dw(7), dw(6), dw(5), dw(4)});
      exp_q.push_back({1'b0, 16'hFFFF, dw(103), dw(102), dw(101), dw(100)});
      exp_q.push_back({1'b1, 16'h00FF, 64'h0, dw(105), dw(104)});
      checks++;
      if (obs_q.size() !== o0 + exp_q.size()) begin
         errors++; $display("FAIL b2b_beats: got %0d expected %0d", obs_q.size() - o0, exp_q.size());
      end else foreach (exp_q[k]) begin
         checks++;
         if (obs_q[o0 + k] !== exp_q[k]) begin
            errors++; $display("FAIL b2b_beat%0d: got %h expected %h", k, obs_q[o0 + k], exp_q[k]);
         end
      end
      exp_q.delete();
      checks++;
      if (desc_q.size() !== d0 + 2 || desc_q[d0] !== mk_desc(1'b1, 11'd8, 32'h3000, 16'h0300, 8'h31, 4'hF, 4'hF, 3'd1, 2'd0, 8'h04) ||
          desc_q[d0 + 1] !== mk_desc(1'b1, 11'd6, 32'h3100, 16'h0301, 8'h32, 4'hE, 4'h3, 3'd0, 2'd0, 8'h04)) begin
         errors++; $display("FAIL b2b_desc: got count %0d expected len8 then len6 descriptors", desc_q.size() - d0);
      end
      checks++;
      if (err_cnt !== e0) begin
         errors++; $display("FAIL b2b_err_len: got %0d pulses expected 0", err_cnt - e0);
      end
   endtask

   task automatic test_mwr_len5();
      int o0;
      o0 = obs_q.size();
      drive_beat(mk_hdr(1'b1, 10'd5, 3'd0, 16'h0500, 8'h41, 4'hF, 4'hF, 32'h0000_5000, dw(10)), 1'b0, 8'h08);
      wr_tready = 1'b0;
      fork
         drive_beat({dw(14), dw(13), dw(12), dw(11)}, 1'b1, 8'h00);
         begin
            @(negedge user_clk);
            checks++;
            if (m_axis_cq_tready !== 4'h0 || wr_tvalid !== 1'b1) begin
               errors++; $display("FAIL data_stall: got rdy=%h v=%b expected 0 1", m_axis_cq_tready, wr_tvalid);
            end
            idle(2);
            wr_tready = 1'b1;
         end
      join
      checks++;
      if (m_axis_cq_tready !== 4'h0 || wr_tvalid !== 1'b1 || wr_tdata !== {96'b0, dw(14)} ||
          wr_tkeep !== 16'h000F || wr_tlast !== 1'b1) begin
         errors++;
         $display("FAIL len5_flush: got rdy=%h v=%b data=%h keep=%h last=%b expected 0 1 %h 000f 1",
                  m_axis_cq_tready, wr_tvalid, wr_tdata, wr_tkeep, wr_tlast, dw(14));
      end
      idle(2);
      exp_q.push_back({1'b0, 16'hFFFF, dw(13), dw(12), dw(11), dw(10)});
      exp_q.push_back({1'b1, 16'h000F, 96'b0, dw(14)});
      checks++;
      if (obs_q.size() !== o0 + exp_q.size()) begin
         errors++; $display("FAIL len5_beats: got %0d expected %0d", obs_q.size() - o0, exp_q.size());
      end else foreach (exp_q[k]) begin
         checks++;
         if (obs_q[o0 + k] !== exp_q[k]) begin
            errors++; $display("FAIL len5_beat%0d: got %h expected %h", k, obs_q[o0 + k], exp_q[k]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_desc_backpressure();
      int d0, rr;
      d0 = desc_q.size();
      rr = 0;
      req_ready = 1'b0;
      drive_beat(mk_hdr(1'b0, 10'd2, 3'd0, 16'h0600, 8'hA1, 4'hF, 4'hF, 32'h0000_6000, 32'h0), 1'b1, 8'h01);
      fork
         drive_beat(mk_hdr(1'b0, 10'd4, 3'd3, 16'h0601, 8'hB2, 4'h1, 4'h8, 32'h0000_6100, 32'h0), 1'b1, 8'h02);
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge user_clk);
               checks++;
               if (m_axis_cq_tready !== 4'h0 || req_valid !== 1'b1 || req_tag !== 8'hA1 || req_addr !== 32'h6000) begin
                  errors++;
                  $display("FAIL bp_hold%0d: got rdy=%h v=%b tag=%h addr=%h expected 0 1 a1 00006000",
                           i, m_axis_cq_tready, req_valid, req_tag, req_addr);
               end
            end
            idle(1);
            req_ready = 1'b1;
            rr = cyc;
         end
      join
      checks++;
      if (cyc !== rr + 1) begin
         errors++; $display("FAIL bp_same_cycle: got accept %0d cycles after req_ready expected 1", cyc - rr);
      end
      checks++;
      if (req_valid !== 1'b1 || req_tag !== 8'hB2) begin
         errors++; $display("FAIL bp_second: got v=%b tag=%h expected 1 b2", req_valid, req_tag);
      end
      idle(2);
      checks++;
      if (desc_q.size() !== d0 + 2 || desc_q[d0] !== mk_desc(1'b0, 11'd2, 32'h6000, 16'h0600, 8'hA1, 4'hF, 4'hF, 3'd0, 2'd0, 8'h01) ||
          desc_q[d0 + 1] !== mk_desc(1'b0, 11'd4, 32'h6100, 16'h0601, 8'hB2, 4'h8, 4'h1, 3'd3, 2'd0, 8'h02)) begin
         errors++; $display("FAIL bp_order: got count %0d expected descriptors a1 then b2", desc_q.size() - d0);
      end
   endtask

   task automatic test_len1024();
      int o0, d0;
      logic [127:0] d;
      o0 = obs_q.size();
      d0 = desc_q.size();
      drive_beat(mk_hdr(1'b1, 10'd0, 3'd2, 16'h0400, 8'h44, 4'hF, 4'hF, 32'h0000_4000, dw(0)), 1'b0, 8'h10);
      for (int k = 1; k <= 256; k++) begin
         if (k < 256) d = {dw(4 * k), dw(4 * k - 1), dw(4 * k - 2), dw(4 * k - 3)};
         else         d = {32'h0, dw(1023), dw(1022), dw(1021)};
         drive_beat(d, (k == 256), 8'h00);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(2);
      for (int j = 0; j < 256; j++)
         exp_q.push_back({(j == 255), 16'hFFFF, dw(4 * j + 3), dw(4 * j + 2), dw(4 * j + 1), dw(4 * j)});
      checks++;
      if (obs_q.size() !== o0 + exp_q.size()) begin
         errors++; $display("FAIL len1024_beats: got %0d expected %0d", obs_q.size() - o0, exp_q.size());
      end else foreach (exp_q[k]) begin
         checks++;
         if (obs_q[o0 + k] !== exp_q[k]) begin
            errors++; $display("FAIL len1024_beat%0d: got %h expected %h", k, obs_q[o0 + k], exp_q[k]);
         end
      end
      exp_q.delete();
      checks++;
      if (desc_q.size() !== d0 + 1 || desc_q[d0] !== mk_desc(1'b1, 11'd1024, 32'h4000, 16'h0400, 8'h44, 4'hF, 4'hF, 3'd2, 2'd0, 8'h10)) begin
         errors++; $display("FAIL len1024_desc: got count %0d expected one len1024 descriptor", desc_q.size() - d0);
      end
   endtask

   task automatic test_len_err();
      int o0, d0, e0;
      o0 = obs_q.size();
      d0 = desc_q.size();
      e0 = err_cnt;
      drive_beat(mk_hdr(1'b1, 10'd8, 3'd0, 16'h0700, 8'h51, 4'hF, 4'hF, 32'h0000_7000, dw(20)), 1'b0, 8'h01);
      drive_beat({dw(24), dw(23), dw(22), dw(21)}, 1'b1, 8'h00);
      checks++;
      if (err_len !== 1'b1 || m_axis_cq_tready !== 4'hF || wr_tvalid !== 1'b0) begin
         errors++; $display("FAIL short_write_pulse: got err=%b rdy=%h v=%b expected 1 f 0", err_len, m_axis_cq_tready, wr_tvalid);
      end
      idle(1);
      checks++;
      if (err_len !== 1'b0) begin
         errors++; $display("FAIL short_write_width: got err=%b expected 0", err_len);
      end
      drive_beat(mk_hdr(1'b0, 10'd1, 3'd0, 16'h0701, 8'h52, 4'h0, 4'hF, 32'h0000_7100, 32'h0), 1'b0, 8'h01);
      drive_beat({4{32'h1234_5678}}, 1'b0, 8'h00);
      drive_beat({4{32'h4000_0001}}, 1'b1, 8'h00);
      drive_beat(mk_hdr(1'b0, 10'd1, 3'd0, 16'h0702, 8'h53, 4'h0, 4'hF, 32'h0000_7200, 32'h0), 1'b1, 8'h01);
      idle(2);
      checks++;
      if (obs_q.size() !== o0 + 1 || obs_q[o0] !== {1'b1, 16'hFFFF, dw(23), dw(22), dw(21), dw(20)}) begin
         errors++; $display("FAIL short_write_beat: got count %0d expected one truncated beat with tlast", obs_q.size() - o0);
      end
      checks++;
      if (err_cnt !== e0 + 2) begin
         errors++; $display("FAIL len_err_count: got %0d pulses expected 2", err_cnt - e0);
      end
      checks++;
      if (desc_q.size() !== d0 + 3 || desc_q[d0 + 1] !== mk_desc(1'b0, 11'd1, 32'h7100, 16'h0701, 8'h52, 4'hF, 4'h0, 3'd0, 2'd0, 8'h01) ||
          desc_q[d0 + 2] !== mk_desc(1'b0, 11'd1, 32'h7200, 16'h0702, 8'h53, 4'hF, 4'h0, 3'd0, 2'd0, 8'h01)) begin
         errors++; $display("FAIL drop_desc: got count %0d expected 3 descriptors ending 52,53", desc_q.size() - d0);
      end
   endtask

   task automatic test_reset_mid_data();
      int o0, d0;
      o0 = obs_q.size();
      d0 = desc_q.size();
      drive_beat(mk_hdr(1'b1, 10'd8, 3'd0, 16'h0800, 8'h61, 4'hF, 4'hF, 32'h0000_8000, dw(30)), 1'b0, 8'h01);
      m_axis_cq_tdata  = {dw(34), dw(33), dw(32), dw(31)};
      m_axis_cq_tvalid = 1'b1;
      #1;
      checks++;
      if (wr_tvalid !== 1'b1) begin
         errors++; $display("FAIL mid_data_valid: got %b expected 1", wr_tvalid);
      end
      user_reset_n = 1'b0;
      #1;
      checks++;
      if (wr_tvalid !== 1'b0 || m_axis_cq_tready !== 4'h0 || req_valid !== 1'b0) begin
         errors++; $display("FAIL reset_mid_data: got v=%b rdy=%h req_v=%b expected 0 0 0", wr_tvalid, m_axis_cq_tready, req_valid);
      end
      m_axis_cq_tvalid = 1'b0;
      idle(2);
      user_reset_n = 1'b1;
      drive_beat(mk_hdr(1'b0, 10'd3, 3'd0, 16'h0801, 8'h62, 4'h1, 4'h2, 32'h0000_8100, 32'h0), 1'b1, 8'h20);
      idle(2);
      checks++;
      if (obs_q.size() !== o0 || desc_q.size() !== d0 + 1 ||
          desc_q[d0] !== mk_desc(1'b0, 11'd3, 32'h8100, 16'h0801, 8'h62, 4'h2, 4'h1, 3'd0, 2'd0, 8'h20)) begin
         errors++; $display("FAIL after_reset_hdr: got beats %0d descs %0d expected 0 beats and descriptor 62",
                            obs_q.size() - o0, desc_q.size() - d0);
      end
   endtask

   initial begin
      test_reset();
      test_mrd();
      test_mwr_len1();
      test_mwr_back_to_back();
      test_mwr_len5();
      test_desc_backpressure();
      test_len1024();
      test_len_err();
      test_reset_mid_data();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cq_req_depacketizer.md
Name: cq_req_depacketizer

Overview:
- Sits directly downstream of the CQ adapter and consumes its legacy-format completer-request stream (128-bit, header in first beat).
- Splits each request into a descriptor channel (header fields, bar info) and a write-payload channel realigned so payload DW0 lands in tdata[31:0].
- Feeds the LitePCIe request dispatcher / CSR bridge.
- Read requests produce a descriptor only; write requests produce a descriptor plus a payload stream.

Parameters:
- DATA_WIDTH, 128, stream width; only 128 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, byte-keep width.

Ports:
- user_clk  in  1  sole clock.
- user_reset_n  in  1  reset, asynchronous, active-low.
- m_axis_cq_tdata  in  128  beat 0: DW0=[31:0] fmt/type/len, DW1=[63:32] {reqid,tag,be}, DW2=[95:64] addr, DW3=[127:96] first payload DW (writes only).
- m_axis_cq_tkeep  in  16  byte keep.
- m_axis_cq_tlast  in  1  end of TLP.
- m_axis_cq_tready  out  4  all four bits identical.
- m_axis_cq_tuser  in  85  [9:2] barhit, [0] ecrc error.
- m_axis_cq_tvalid  in  1  beat valid.
- req_valid  out  1  descriptor valid.
- req_ready  in  1  descriptor accepted.
- req_we  out  1  1=write (fmt[1]).
- req_len  out  11  DW count 1..1024.
- req_addr  out  32  DW2.
- req_reqid  out  16  requester id.
- req_tag  out  8  tag.
- req_first_be  out  4  first-DW byte enables.
- req_last_be  out  4  last-DW byte enables.
- req_tc  out  3  traffic class.
- req_attr  out  2  attributes.
- req_barhit  out  8  tuser[9:2] of header beat.
- wr_tdata  out  128  realigned payload.
- wr_tkeep  out  16  per-DW nibble keep.
- wr_tlast  out  1  last payload beat.
- wr_tvalid  out  1  payload valid.
- wr_tready  in  1  payload accepted.
- err_len  out  1  one-cycle pulse on length mismatch.

Behaviour:
- Reset (async assert, sync release): state=HDR; req_valid=0, wr_tvalid=0, wr_tlast=0, err_len=0, m_axis_cq_tready=0; descriptor registers=0. Reset mid-packet discards the packet; remaining input beats after release are treated as HDR.
- Length decode: req_len = (DW0[9:0]==0) ? 1024 : DW0[9:0], 11-bit. first_be=DW1[3:0], last_be=DW1[7:4], tag=DW1[15:8], reqid=DW1[31:16], tc=DW0[22:20], attr=DW0[5:4], we=DW0[30].
- Descriptor: registered; req_valid rises the cycle after the header beat is accepted and holds with stable fields until req_valid&&req_ready. Only one descriptor is pending at a time.
- HDR: tready = !req_valid || req_ready.
  - On accept of a read: latch the descriptor; stay in HDR. The beat must have tlast; if not, pulse err_len and go to DROP.
  - On accept of a write: carry<=DW3, rem<=req_len.
    - If tlast and len==1: go to FLUSH.
    - Else if tlast: pulse err_len, go to FLUSH.
    - Else: go to DATA.
- DATA: tready=wr_tready; wr_tvalid=m_axis_cq_tvalid; wr_tdata={in[95:0], carry}. On handshake:
  - rem<=4: tkeep = nibble mask of rem DWs, wr_tlast=1, go to HDR. If input tlast is absent, pulse err_len and go to DROP.
  - rem>4: tkeep=FFFF, carry<=in DW3, rem<=rem-4.
    - If input tlast and rem==5: go to FLUSH.
    - If input tlast and rem>5: wr_tlast=1, pulse err_len, go to HDR.
- FLUSH: tready=0; wr_tvalid=1, wr_tdata={96'b0, carry}, wr_tkeep=000F, wr_tlast=1; go to HDR on wr_tready.
- DROP: tready=1, wr_tvalid=0; go to HDR after a tlast beat.
- Channel independence: the payload channel does not wait for the descriptor handshake; the descriptor may be accepted before, during or after the payload.
- Latency: descriptor 1 cycle after header accept; payload combinational from input plus carry (0 cycles); FLUSH beat 1 cycle after the last input beat.
- Ordering: back-to-back headers are accepted with no idle cycle when req_ready is high.

Test Plan:
- MRd len=1 addr=0x1000 tag=0x12 be=F, tlast on beat 0, tuser[9:2]=0x01 -> next cycle req_valid=1, we=0, len=1, addr=0x1000, tag=0x12, barhit=0x01; no wr_tvalid.
- MWr len=1 DW3=0xDEADBEEF, tlast on beat 0 -> FLUSH beat wr_tdata[31:0]=DEADBEEF, tkeep=000F, tlast=1; m_axis_cq_tready=0 during FLUSH.
- MWr len=8 D0..D7 in 3 input beats (last keep=0FFF) -> out {D3..D0} keep FFFF, then {D7..D4} keep FFFF tlast; req_len=8.
- MWr len=5 D0..D4 in 2 input beats -> out {D3..D0}, then FLUSH {0,0,0,D4} keep 000F tlast.
- req_ready=0 with MRd pending, second MRd presented -> tready=0 until req_ready=1, then second header accepted the same cycle.
- MWr len=0 (1024 DW) -> req_len=1024, 256 output beats, tlast on beat 256. Separately: MWr len=8 with tlast on beat 1 -> err_len pulse, wr_tlast asserted, state HDR. Separately: assert reset mid-DATA -> wr_tvalid=0 immediately.
